// File: rtl/player_ctrl_multi.sv
// player_ctrl_multi: position, health and immunity for NUM_PLAYERS independent players.
// Define HEAL_EN to let the heal strobes restore health (saturating at MAX_HP).
module player_ctrl_multi #(
  parameter int NUM_PLAYERS   = 2,
  parameter int X_W           = 10,
  parameter int HP_W          = 2,
  parameter int MAX_HP        = 3,
  parameter int START_X       = 300,
  parameter int START_SPACING = 200,
  parameter int PLAYER_W      = 30,
  parameter int STEP          = 15,
  parameter int LEFT_BOUNDARY = 144,
  parameter int RIGHT_BOUNDARY = 784,
  parameter int TMR_W         = 32
) (
  input  logic                        clk_master,
  input  logic                        rst,
  input  logic                        pulse_stepCycle,
  input  logic [NUM_PLAYERS-1:0]      mv_left,
  input  logic [NUM_PLAYERS-1:0]      mv_right,
  input  logic [NUM_PLAYERS-1:0]      hit,
  input  logic [NUM_PLAYERS-1:0]      heal,
  input  logic [TMR_W-1:0]            delay,
  output logic [NUM_PLAYERS*X_W-1:0]  player_x,
  output logic [NUM_PLAYERS*HP_W-1:0] player_hp,
  output logic [NUM_PLAYERS-1:0]      immune,
  output logic [NUM_PLAYERS-1:0]      alive,
  output logic                        game_over
);
  typedef enum logic [1:0] {ALIVE, IMMUNE, DEAD} state_t;
  localparam int XE = X_W + 2;
  logic [TMR_W-1:0]       eff_delay;
  logic [NUM_PLAYERS-1:0] dead;
  assign eff_delay = (delay == '0) ? TMR_W'(1) : delay;
  assign game_over = &dead;
`ifndef HEAL_EN
  logic heal_unused;
  assign heal_unused = ^heal;
`endif
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_p
    state_t          state_q;
    logic [X_W-1:0]  x_q, x_d;
    logic [HP_W-1:0] hp_q;
    logic [TMR_W-1:0] tmr_q;
    logic [XE-1:0]   xe;
    logic            can_l, can_r, go_l, go_r, heal_ok;
    // widened compares so x near the top of X_W cannot wrap past the boundary
    assign xe    = XE'(x_q);
    assign can_l = xe >= XE'(LEFT_BOUNDARY + STEP);
    assign can_r = xe + XE'(STEP + PLAYER_W) <= XE'(RIGHT_BOUNDARY);
    assign go_l  = pulse_stepCycle && state_q != DEAD && mv_left[i] && !mv_right[i] && can_l;
    assign go_r  = pulse_stepCycle && state_q != DEAD && mv_right[i] && !mv_left[i] && can_r;
    assign x_d   = go_l ? x_q - X_W'(STEP) : go_r ? x_q + X_W'(STEP) : x_q;
`ifdef HEAL_EN
    assign heal_ok = heal[i] && hp_q != HP_W'(MAX_HP);
`else
    assign heal_ok = 1'b0;
`endif
    always_ff @(posedge clk_master) begin
      if (rst) begin
        state_q <= ALIVE;
        x_q     <= X_W'(START_X + i * START_SPACING);
        hp_q    <= HP_W'(MAX_HP);
        tmr_q   <= '0;
      end else begin
        x_q <= x_d;
        case (state_q)
          ALIVE:
            if (hit[i]) begin
              hp_q    <= hp_q - HP_W'(1);
              tmr_q   <= '0;
              state_q <= (hp_q > HP_W'(1)) ? IMMUNE : DEAD;
            end else if (heal_ok) hp_q <= hp_q + HP_W'(1);
          IMMUNE: begin
            tmr_q <= tmr_q + TMR_W'(1);
            if (tmr_q == eff_delay - TMR_W'(1)) state_q <= ALIVE;
            if (heal_ok) hp_q <= hp_q + HP_W'(1);
          end
          default: ;
        endcase
      end
    end
    assign player_x[i*X_W +: X_W]    = x_q;
    assign player_hp[i*HP_W +: HP_W] = hp_q;
    assign immune[i] = state_q == IMMUNE;
    assign alive[i]  = state_q != DEAD;
    assign dead[i]   = state_q == DEAD;
  end
endmodule

// File: tb/tb_player_ctrl_multi.sv
// tb_player_ctrl_multi: randomized scoreboard bench against a count-down behavioural model.
module tb_player_ctrl_multi;
  localparam int NP = 2, X_W = 10, HP_W = 2, MAX_HP = 3, START_X = 300, START_SPACING = 200;
  localparam int PLAYER_W = 30, STEP = 15, LB = 144, RB = 784, TMR_W = 32;
  typedef struct packed {
    logic [NP*X_W-1:0]  x;
    logic [NP*HP_W-1:0] hp;
    logic [NP-1:0]      imm;
    logic [NP-1:0]      alv;
    logic               go;
  } exp_t;
  logic clk_master = 0, rst = 0, pulse_stepCycle = 0;
  logic [NP-1:0] mv_left = '0, mv_right = '0, hit = '0, heal = '0;
  logic [TMR_W-1:0] delay = '0;
  logic [NP*X_W-1:0] player_x;
  logic [NP*HP_W-1:0] player_hp;
  logic [NP-1:0] immune, alive;
  logic game_over;
  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0;
  int mx[NP], mhp[NP], mrem[NP];
  always #5 clk_master = ~clk_master;
  player_ctrl_multi dut (
    .clk_master(clk_master), .rst(rst), .pulse_stepCycle(pulse_stepCycle),
    .mv_left(mv_left), .mv_right(mv_right), .hit(hit), .heal(heal), .delay(delay),
    .player_x(player_x), .player_hp(player_hp), .immune(immune), .alive(alive),
    .game_over(game_over)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // mrem counts the immune cycles still to be shown; a player is dead exactly when its hp is 0
  task automatic model_step();
    int eff = (delay == 0) ? 1 : int'(delay);
    for (int i = 0; i < NP; i++) begin
      if (rst) begin
        mx[i] = START_X + i * START_SPACING; mhp[i] = MAX_HP; mrem[i] = 0;
      end else if (mhp[i] > 0) begin
        if (pulse_stepCycle && mv_left[i] && !mv_right[i] && mx[i] >= LB + STEP) mx[i] -= STEP;
        if (pulse_stepCycle && mv_right[i] && !mv_left[i] && mx[i] + STEP + PLAYER_W <= RB) mx[i] += STEP;
        if (mrem[i] > 0) begin
          mrem[i]--;
`ifdef HEAL_EN
          if (heal[i] && mhp[i] < MAX_HP) mhp[i]++;
`endif
        end else if (hit[i]) begin
          mhp[i]--;
          mrem[i] = (mhp[i] > 0) ? eff : 0;
        end
`ifdef HEAL_EN
        else if (heal[i] && mhp[i] < MAX_HP) mhp[i]++;
`endif
      end
    end
  endtask
  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.go = 1'b1;
    for (int i = 0; i < NP; i++) begin
      e.x[i*X_W +: X_W]    = X_W'(mx[i]);
      e.hp[i*HP_W +: HP_W] = HP_W'(mhp[i]);
      e.imm[i] = mrem[i] > 0;
      e.alv[i] = mhp[i] > 0;
      if (mhp[i] > 0) e.go = 1'b0;
    end
    return e;
  endfunction
  always @(posedge clk_master) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("player_x", 32'(player_x), 32'(mon_e.x));
      check("player_hp", 32'(player_hp), 32'(mon_e.hp));
      check("immune", 32'(immune), 32'(mon_e.imm));
      check("alive", 32'(alive), 32'(mon_e.alv));
      check("game_over", 32'(game_over), 32'(mon_e.go));
    end
  end
  initial begin
    int mode[NP];
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 150; c++) begin
        @(negedge clk_master);
        rst = (c == 0) || ($urandom_range(0, 199) == 0);
        if (c == 0) delay = (r % 4 == 0) ? '0 : TMR_W'($urandom_range(1, 8));
        if (c % 40 == 0) for (int i = 0; i < NP; i++) mode[i] = $urandom_range(0, 3);
        pulse_stepCycle = 1'($urandom_range(0, 1));
        for (int i = 0; i < NP; i++) begin
          mv_left[i]  = mode[i] == 0 || mode[i] == 2 || (mode[i] == 3 && $urandom_range(0, 1) == 1);
          mv_right[i] = mode[i] == 1 || mode[i] == 2 || (mode[i] == 3 && $urandom_range(0, 1) == 1);
          hit[i]  = $urandom_range(0, 11) == 0;
          heal[i] = $urandom_range(0, 5) == 0;
        end
        model_step();
        sb.push_back(model_out());
      end
    end
    @(negedge clk_master);
    rst = 0; pulse_stepCycle = 0; mv_left = '0; mv_right = '0; hit = '0; heal = '0;
    @(negedge clk_master);
    check("drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/player_ctrl_multi.md
Name: player_ctrl_multi

Overview:
Parametrised successor to the single-player controller. Tracks position, health and immunity for NUM_PLAYERS independent players in one block. Movement is rate-limited to the step-cycle pulse, and each player runs an explicit ALIVE/IMMUNE/DEAD state machine. The block sits between the input decoder / collision detector and the VGA renderer, and it drives game_over to the top-level game FSM.

Parameters:
NUM_PLAYERS, 2, number of independent player channels (1..4)
X_W, 10, width of each X coordinate
HP_W, 2, width of each health field
MAX_HP, 3, health after reset (must fit in HP_W)
START_X, 300, reset X of player 0
START_SPACING, 200, reset X of player i = START_X + i*START_SPACING
PLAYER_W, 30, player sprite width in pixels
STEP, 15, pixels moved per step pulse
LEFT_BOUNDARY, 144, leftmost legal X
RIGHT_BOUNDARY, 784, rightmost legal X+PLAYER_W
TMR_W, 32, width of the immunity timer and of delay

Ports:
clk_master  in  1  system clock
rst  in  1  reset, synchronous, active-high
pulse_stepCycle  in  1  one-cycle movement enable strobe
mv_left  in  NUM_PLAYERS  per-player move-left request (level)
mv_right  in  NUM_PLAYERS  per-player move-right request (level)
hit  in  NUM_PLAYERS  per-player hit strobe from collision logic
heal  in  NUM_PLAYERS  per-player heal strobe (used only with HEAL_EN)
delay  in  TMR_W  immunity length in clk_master cycles
player_x  out  NUM_PLAYERS*X_W  packed X positions, player i at bits [i*X_W +: X_W]
player_hp  out  NUM_PLAYERS*HP_W  packed health values
immune  out  NUM_PLAYERS  1 while the player is in IMMUNE
alive  out  NUM_PLAYERS  1 while the player is not DEAD
game_over  out  1  1 when every player is DEAD

Behaviour:
- All state is registered on the clk_master rising edge. rst has priority over all other inputs.
- Reset values:
  - player_x[i] = START_X + i*START_SPACING
  - player_hp[i] = MAX_HP
  - state = ALIVE, so immune = 0 and alive = 1
  - timers = 0
  - game_over = 0
- Per-player FSM states: ALIVE, IMMUNE, DEAD.
- ALIVE, hit=1:
  - If hp > 1: hp decrements, the timer clears to 0, and the next state is IMMUNE.
  - If hp == 1: hp becomes 0 and the next state is DEAD.
- IMMUNE:
  - hit is ignored.
  - The timer increments each cycle.
  - When the timer == eff_delay-1, the next state is ALIVE.
  - eff_delay = delay, or 1 when delay == 0. immune is therefore high for exactly eff_delay cycles.
- DEAD: terminal until rst. hit, heal and movement are all ignored, and player_x holds.
- Movement is evaluated only in cycles where pulse_stepCycle == 1 and the player is not DEAD; immune players may move.
  - mv_left alone: x <= x - STEP, only if x >= LEFT_BOUNDARY + STEP; otherwise hold.
  - mv_right alone: x <= x + STEP, only if x + STEP + PLAYER_W <= RIGHT_BOUNDARY; otherwise hold.
  - Both or neither asserted: hold.
  - All comparisons use X_W+2-bit unsigned arithmetic, so there is no wrap.
- Movement and hit processing are independent: a hit and a move in the same cycle both take effect.
- Channels are fully independent; there are no cross-player interactions.
- Output derivation:
  - game_over = AND of all DEAD flags, derived combinationally from state registers with zero added latency.
  - alive[i] = state != DEAD.
- A rst mid-immunity or after game over restores reset values on the next edge.
- delay changing mid-immunity takes effect immediately. If the timer already exceeds eff_delay-1, exit occurs when the timer wraps; TMR_W=32 makes this practically unreachable, and benches must not rely on it.

Optional Feature:
HEAL_EN
- Defined: in ALIVE or IMMUNE, heal=1 with hit not taking effect that cycle increments hp, saturating at MAX_HP.
  - In ALIVE, a simultaneous hit wins and heal is dropped.
  - In IMMUNE, heal applies because the hit is ignored.
  - heal never leaves the DEAD state.
- Undefined: the heal port exists but is ignored, and hp never increases except on reset.

Test Plan:
1. Reset, NUM_PLAYERS=2 -> player_x = {500,300}, hp = {3,3}, immune = 00, alive = 11, game_over = 0.
2. P0 mv_left held for 20 step pulses from x=300 -> 300,285,...,165,150, then holds at 150 since 150 < 159; mv_right and mv_left both high -> no change; no pulse_stepCycle -> no movement.
3. delay=5, hit[0] one cycle -> hp0=2 next edge, immune[0] high exactly 5 cycles; a further hit[0] during immunity -> hp0 stays 2.
4. delay=0, hit P1 three times spaced 3 cycles apart -> hp1 goes 2,1,0; immune pulses 1 cycle each time; alive[1]=0 after the third hit; game_over stays 0.
5. Kill both players -> game_over=1 same cycle as the last DEAD; moves and hits are ignored; rst -> full reset values next edge.
6. HEAL_EN: hp=1 IMMUNE with heal -> hp=2; heal at hp=3 -> stays 3; ALIVE with hit+heal same cycle -> hp decrements only.
